// File: rtl/br_arb_lru_pkt_mux.sv
// br_arb_lru_pkt_mux: packet-aware least-recently-used mux that shares one
// downstream valid/ready channel among NumRequesters upstream sources.
//
// Handshake: a beat moves on a channel in any cycle where valid && ready.
// An offered beat (valid=1, ready=0) must be held with stable data/last
// until accepted. push_ready[i] = pop_ready && (selected == i), so ready
// never waits on the requester's own valid.
//
// The grant is locked to one requester from its first offered beat until its
// last beat is accepted. The LRU order is updated only when a packet completes.
// The FSM state is visible as state_q (IDLE/LOCKED) for checkers.
module br_arb_lru_pkt_mux #(
    parameter int NumRequesters = 2,
    parameter int Width         = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NumRequesters-1:0]         push_valid,
    output logic [NumRequesters-1:0]         push_ready,
    input  logic [NumRequesters-1:0]         push_last,
    input  logic [NumRequesters*Width-1:0]   push_data,
    output logic                             pop_valid,
    input  logic                             pop_ready,
    output logic                             pop_last,
    output logic [Width-1:0]                 pop_data,
    output logic [$clog2(NumRequesters)-1:0] pop_sel
);

    localparam int SelW = $clog2(NumRequesters);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [SelW-1:0]          sel_q, sel_d;
    logic [SelW-1:0]          sel;
    logic [SelW-1:0]          win_idx;
    logic [NumRequesters-1:0] win_vec;
    logic                     acc;
    logic                     lru_upd;

    // higher_q[i][j] = 1 means requester i currently outranks requester j.
    // The matrix is kept antisymmetric so the order is always a strict total order.
    logic [NumRequesters-1:0] higher_q [NumRequesters];
    logic [NumRequesters-1:0] higher_d [NumRequesters];

    // LRU winner: the valid requester that outranks every other valid requester.
    always_comb begin
        win_vec = '0;
        win_idx = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            win_vec[i] = push_valid[i];
            for (int j = 0; j < NumRequesters; j++) begin
                if (j != i && push_valid[j] && !higher_q[i][j]) begin
                    win_vec[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NumRequesters; i++) begin
            if (win_vec[i]) begin
                win_idx = SelW'(i);
            end
        end
    end

    // Datapath steering, handshake outputs, lock FSM and LRU next-state.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        higher_d = higher_q;
        lru_upd  = 1'b0;

        sel = (state_q == LOCKED) ? sel_q : win_idx;

        pop_valid = 1'b0;
        if (!rst) begin
            pop_valid = (state_q == LOCKED) ? push_valid[sel] : |push_valid;
        end
        pop_last = push_last[sel];
        pop_data = push_data[int'(sel)*Width +: Width];
        pop_sel  = sel;

        push_ready = '0;
        for (int i = 0; i < NumRequesters; i++) begin
            push_ready[i] = !rst && pop_ready && (sel == SelW'(i));
        end

        acc = pop_valid && pop_ready;

        case (state_q)
            IDLE: begin
                if (pop_valid) begin
                    if (acc && pop_last) begin
                        lru_upd = 1'b1;
                    end else begin
                        // Either the packet continues or the beat stalled:
                        // hold the grant so it cannot switch mid-offer.
                        state_d = LOCKED;
                        sel_d   = sel;
                    end
                end
            end
            LOCKED: begin
                if (acc && pop_last) begin
                    state_d = IDLE;
                    lru_upd = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completed packet: granted requester drops below everyone else,
        // all other pairwise relations are untouched.
        if (lru_upd) begin
            for (int j = 0; j < NumRequesters; j++) begin
                if (SelW'(j) != sel) begin
                    higher_d[sel][j] = 1'b0;
                    higher_d[j][sel] = 1'b1;
                end
            end
        end
    end

    // State registers; reset restores IDLE and index order 0 (highest) .. N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            for (int i = 0; i < NumRequesters; i++) begin
                for (int j = 0; j < NumRequesters; j++) begin
                    higher_q[i][j] <= (i < j);
                end
            end
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            higher_q <= higher_d;
        end
    end

    // Grant sanity properties.
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(push_ready));
    a_valid_source : assert property (@(posedge clk) disable iff (rst)
        pop_valid |-> push_valid[pop_sel]);
    a_acc_ready : assert property (@(posedge clk) disable iff (rst)
        (pop_valid && pop_ready) |-> push_ready[pop_sel]);

endmodule

// File: tb/tb_br_arb_lru_pkt_mux.sv
// Testbench for br_arb_lru_pkt_mux (N=4, 8-bit payload): directed packet
// scenarios followed by randomized traffic, all checked against a queue-based
// LRU reference model.
module tb_br_arb_lru_pkt_mux;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   push_valid;
    logic [N-1:0]   push_ready;
    logic [N-1:0]   push_last;
    logic [N*W-1:0] push_data;
    logic           pop_valid;
    logic           pop_ready;
    logic           pop_last;
    logic [W-1:0]   pop_data;
    logic [SW-1:0]  pop_sel;

    br_arb_lru_pkt_mux #(
        .NumRequesters(N),
        .Width        (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_last (push_last),
        .push_data (push_data),
        .pop_valid (pop_valid),
        .pop_ready (pop_ready),
        .pop_last  (pop_last),
        .pop_data  (pop_data),
        .pop_sel   (pop_sel)
    );

    // ---------------- scoreboard counters ----------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // order[0] is the highest priority requester; a finished packet moves its
    // owner to the back of the queue.
    int           order[$];
    bit           m_locked;
    int           m_owner;
    bit           exp_valid;
    int           exp_sel;
    logic [N-1:0] exp_ready;
    int           wait_pkts[N];

    function automatic logic [15:0] packed_order();
        logic [15:0] p = '0;
        foreach (order[k]) p = {p[11:0], 4'(order[k])};
        return p;
    endfunction

    // Model state advance on every active edge.
    always @(posedge clk) begin
        if (rst) begin
            order    = {0, 1, 2, 3};
            m_locked = 1'b0;
            m_owner  = 0;
        end else if (exp_valid) begin
            if (pop_ready && push_last[exp_sel]) begin
                int idx = 0;
                foreach (order[k]) if (order[k] == exp_sel) idx = k;
                order.delete(idx);
                order.push_back(exp_sel);
                m_locked = 1'b0;
            end else begin
                m_locked = 1'b1;
                m_owner  = exp_sel;
            end
        end
    end

    // Compare process: derive expectations mid-cycle and check DUT outputs.
    always @(negedge clk) begin
        exp_valid = 1'b0;
        exp_sel   = 0;
        exp_ready = '0;
        if (!rst) begin
            if (m_locked) begin
                exp_sel   = m_owner;
                exp_valid = push_valid[m_owner];
            end else begin
                foreach (order[k]) begin
                    if (!exp_valid && push_valid[order[k]]) begin
                        exp_valid = 1'b1;
                        exp_sel   = order[k];
                    end
                end
            end
            if (exp_valid || m_locked) exp_ready[exp_sel] = pop_ready;
        end

        check("pop_valid", pop_valid, exp_valid);
        if (exp_valid) begin
            check("pop_sel", pop_sel, exp_sel);
            check("pop_data", pop_data, push_data[exp_sel*W +: W]);
            check("pop_last", pop_last, push_last[exp_sel]);
        end
        if (rst || exp_valid || m_locked) check("push_ready", push_ready, exp_ready);
        else check("ready_onehot0", $onehot0(push_ready), 1);

        // Fairness: count packets finished by others while a requester waits.
        for (int i = 0; i < N; i++) begin
            if (rst || !push_valid[i]) wait_pkts[i] = 0;
        end
        if (!rst && pop_valid && pop_ready && pop_last) begin
            for (int i = 0; i < N; i++) begin
                if (i == int'(pop_sel)) begin
                    wait_pkts[i] = 0;
                end else if (push_valid[i]) begin
                    wait_pkts[i]++;
                    check("fair_wait", wait_pkts[i] <= N - 1, 1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input bit l, input logic [W-1:0] d);
        push_valid[i]       = v;
        push_last[i]        = l;
        push_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        push_valid = '0;
        push_last  = '0;
        tick();
        rst = 1'b0;
    endtask

    int seq_a[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst        = 1'b1;
        push_valid = '1;
        push_last  = '1;
        push_data  = '0;
        pop_ready  = 1'b1;

        // Reset state: nothing offered downstream, nothing accepted upstream.
        @(negedge clk);
        check("rst_pop_valid", pop_valid, 0);
        check("rst_push_ready", push_ready, 0);
        tick();
        rst = 1'b0;

        // A: all valid, single-beat packets -> round-robin-like LRU rotation.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 8'(8'hA0 + i));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("a_sel", pop_sel, seq_a[k]);
            check("a_valid", pop_valid, 1);
            tick();
        end

        // B: req1 3-beat packet, req0 joins one cycle later.
        do_reset();
        set_req(1, 1'b1, 1'b0, 8'h11);
        @(negedge clk); check("b_sel0", pop_sel, 1);
        tick();
        set_req(0, 1'b1, 1'b1, 8'h01);
        set_req(1, 1'b1, 1'b0, 8'h12);
        @(negedge clk); check("b_sel1", pop_sel, 1);
        tick();
        set_req(1, 1'b1, 1'b1, 8'h13);
        @(negedge clk); check("b_sel2", pop_sel, 1);
        tick();
        set_req(1, 1'b0, 1'b0, 8'h00);
        check("b_order_after_pkt", packed_order(), 16'h0231);
        @(negedge clk); check("b_sel3", pop_sel, 0);
        tick();
        check("b_order_after_req0", packed_order(), 16'h2310);
        set_req(0, 1'b0, 1'b0, 8'h00);

        // C: req0 stalled for several cycles, req1 arrives during the stall.
        do_reset();
        pop_ready = 1'b0;
        set_req(0, 1'b1, 1'b1, 8'h5A);
        for (int k = 0; k < 6; k++) begin
            if (k == 5) set_req(1, 1'b1, 1'b1, 8'h6B);
            @(negedge clk);
            check("c_stall_sel", pop_sel, 0);
            check("c_stall_data", pop_data, 8'h5A);
            tick();
        end
        pop_ready = 1'b1;
        @(negedge clk);
        check("c_accept_sel", pop_sel, 0);
        check("c_accept_ready", push_ready, 4'b0001);
        tick();
        set_req(0, 1'b0, 1'b0, 8'h00);
        @(negedge clk); check("c_next_sel", pop_sel, 1);
        tick();
        set_req(1, 1'b0, 1'b0, 8'h00);

        // D: req2 2-beat packet with a 3-cycle gap, req3 waiting throughout.
        do_reset();
        set_req(2, 1'b1, 1'b0, 8'h21);
        set_req(3, 1'b1, 1'b1, 8'h31);
        @(negedge clk); check("d_first_sel", pop_sel, 2);
        tick();
        set_req(2, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("d_gap_valid", pop_valid, 0);
            check("d_gap_ready3", push_ready[3], 0);
            tick();
        end
        set_req(2, 1'b1, 1'b1, 8'h22);
        @(negedge clk);
        check("d_last_sel", pop_sel, 2);
        check("d_last_ready", push_ready, 4'b0100);
        tick();
        set_req(2, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("d_req3_sel", pop_sel, 3);
        check("d_req3_ready", push_ready, 4'b1000);
        tick();
        set_req(3, 1'b0, 1'b0, 8'h00);

        // E: reset while req1 is in the middle of a 4-beat packet.
        do_reset();
        set_req(1, 1'b1, 1'b0, 8'h41);
        tick();
        set_req(1, 1'b1, 1'b0, 8'h42);
        rst = 1'b1;
        @(negedge clk);
        check("e_rst_valid", pop_valid, 0);
        check("e_rst_ready", push_ready, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 8'(8'hE0 + i));
        @(negedge clk); check("e_after_rst_sel", pop_sel, 0);
        tick();

        // F: randomized traffic obeying the upstream hold rule.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 999) == 0);
            pop_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(push_valid[i] && !exp_ready[i])) begin
                    set_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                            8'($urandom_range(0, 255)));
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
